// File: rtl/local_inject_queue.sv
// local_inject_queue
//   Upstream feeder for the router injector stage. Destination addresses pushed
//   by the local PE are buffered in a FIFO. The head entry is presented to the
//   injector as its local address and is popped when the injector has a free
//   outgoing slot. Packets addressed to this node never enter the mesh; they
//   loop straight back to the PE as a one-cycle self_valid pulse.
//
//   Optional feature macro: INJ_STARVE_CNT_EN
//     defined   -> saturating head-wait counter drives a registered starve flag
//     undefined -> starve is tied to 0 (port kept)
//
// Ports
//   clk         in   1            clock, all logic on posedge
//   rst         in   1            synchronous active-high reset
//   push_valid  in   1            PE offers push_addr this cycle
//   push_addr   in   6            destination {row[2:0], col[2:0]}
//   push_ready  out  1            queue accepts a push this cycle (count != DEPTH)
//   head_valid  out  1            head entry present
//   localad     out  6            head address to injector; high-Z when empty
//   inj_ready   in   1            injector free slot; pop = head_valid & inj_ready
//   count       out  clog2(D)+1   occupancy 0..DEPTH
//   self_valid  out  1            one-cycle pulse: self-addressed packet delivered
//   self_addr   out  6            address accompanying self_valid
//   starve      out  1            head has waited STARVE_LIMIT cycles (option)
module local_inject_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned NODE_ROW     = 4,
  parameter int unsigned NODE_COL     = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [5:0]               push_addr,
  output logic                     push_ready,
  output logic                     head_valid,
  output logic [5:0]               localad,
  input  logic                     inj_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     self_valid,
  output logic [5:0]               self_addr,
  output logic                     starve
);

  localparam int unsigned AW = 6;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] SELF_ADDR = {3'(NODE_ROW), 3'(NODE_COL)};

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          self_valid_q, self_valid_d;
  logic [AW-1:0] self_addr_q, self_addr_d;

  logic push_acc;
  logic self_hit;
  logic enq;
  logic pop;

  // Full/empty come from the registered count only, so push_ready never
  // depends combinationally on inj_ready.
  assign push_ready = (count_q != CW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign localad    = head_valid ? mem_q[rd_ptr_q] : {AW{1'bz}};
  assign count      = count_q;
  assign self_valid = self_valid_q;
  assign self_addr  = self_addr_q;

  // Next-state for pointers, occupancy and the loopback pulse.
  always_comb begin
    push_acc     = push_valid && push_ready;
    self_hit     = (push_addr == SELF_ADDR);
    enq          = push_acc && !self_hit;
    pop          = head_valid && inj_ready;

    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    self_valid_d = 1'b0;
    self_addr_d  = self_addr_q;

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (enq && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!enq && pop) begin
      count_d = count_q - CW'(1);
    end

    // Self-addressed packets bypass the FIFO and may overtake queued ones.
    if (push_acc && self_hit) begin
      self_valid_d = 1'b1;
      self_addr_d  = push_addr;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      self_valid_q <= 1'b0;
      self_addr_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      self_valid_q <= self_valid_d;
      self_addr_q  <= self_addr_d;
    end
  end

  // Storage array; contents are don't-care after reset so it is not cleared.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      mem_q[wr_ptr_q] <= push_addr;
    end
  end

`ifdef INJ_STARVE_CNT_EN
  localparam int unsigned WW = $clog2(STARVE_LIMIT) + 1;

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          starve_q, starve_d;

  // Saturating count of cycles the head has been refused by the injector.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!head_valid || pop) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != {WW{1'b1}}) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end
    // Decoded from the next count so the flag drops the cycle after a pop.
    starve_d = (wait_cnt_d >= WW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^32'(STARVE_LIMIT);
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_local_inject_queue.sv
// Scoreboard bench for local_inject_queue (DEPTH=4, node 4,4).
module tb_local_inject_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       push_valid;
  logic [5:0] push_addr;
  logic       push_ready;
  logic       head_valid;
  wire  [5:0] localad;
  logic       inj_ready;
  logic [2:0] count;
  logic       self_valid;
  logic [5:0] self_addr;
  logic       starve;

  localparam logic [5:0] SELF = 6'o44;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] exp_head[$];
  logic [5:0] exp_self[$];

  local_inject_queue #(
    .DEPTH(4), .NODE_ROW(4), .NODE_COL(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_addr(push_addr), .push_ready(push_ready),
    .head_valid(head_valid), .localad(localad), .inj_ready(inj_ready),
    .count(count), .self_valid(self_valid), .self_addr(self_addr),
    .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_float(input string name);
    n_cmp++;
    if (!((localad === 6'bz) || (localad === 6'b0))) begin
      n_err++;
      $display("FAIL %s: localad got 0x%0h expected high-Z", name, localad);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one address, wait (bounded) for acceptance, record expectation.
  task automatic do_push(input logic [5:0] a);
    bit ok = 1'b0;
    push_valid = 1'b1;
    push_addr  = a;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (push_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (a == SELF) exp_self.push_back(a);
      else           exp_head.push_back(a);
    end else begin
      chk("push_accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0;
  endtask

  task automatic drain;
    inj_ready = 1'b1;
    for (int i = 0; i < 20 && head_valid; i++) tick();
    inj_ready = 1'b0;
    chk("drain_empty", int'(head_valid), 0);
  endtask

  // Monitor: compares the head against the scoreboard whenever a pop occurs,
  // and every loopback pulse against the self queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (head_valid && inj_ready) begin
        if (exp_head.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          chk("pop_localad", int'(localad), int'(exp_head.pop_front()));
        end
      end
      if (self_valid) begin
        if (exp_self.size() == 0) begin
          chk("self_unexpected", 1, 0);
        end else begin
          chk("self_addr", int'(self_addr), int'(exp_self.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] tbl [5];
    tbl[0] = 6'o21; tbl[1] = 6'o32; tbl[2] = 6'o43; tbl[3] = 6'o54; tbl[4] = 6'o65;

    // 1: reset with pushes and pops asserted must be overridden
    rst = 1'b1; push_valid = 1'b1; push_addr = 6'o12; inj_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; push_valid = 1'b0; inj_ready = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_head_valid", int'(head_valid), 0);
    chk("rst_push_ready", int'(push_ready), 1);
    chk("rst_self_valid", int'(self_valid), 0);
    chk("rst_self_addr", int'(self_addr), 0);
    chk("rst_starve", int'(starve), 0);
    chk_float("rst_localad");

    // inj_ready while empty has no effect
    inj_ready = 1'b1;
    tick();
    inj_ready = 1'b0;
    chk("empty_pop_count", int'(count), 0);

    // 2: three pushes, then drain in order
    do_push(6'o12);
    chk("t2_head_valid_latency", int'(head_valid), 1);
    chk("t2_count1", int'(count), 1);
    do_push(6'o35);
    do_push(6'o70);
    chk("t2_count3", int'(count), 3);
    chk("t2_head", int'(localad), int'(6'o12));
    inj_ready = 1'b1;
    tick(); chk("t2_count_after_pop1", int'(count), 2);
    chk("t2_head2", int'(localad), int'(6'o35));
    tick(); chk("t2_count_after_pop2", int'(count), 1);
    chk("t2_head3", int'(localad), int'(6'o70));
    tick(); chk("t2_count_after_pop3", int'(count), 0);
    inj_ready = 1'b0;
    chk("t2_empty", int'(head_valid), 0);
    chk_float("t2_localad_z");

    // 3: fill, then hold pushes against a full queue
    do_push(6'o11); do_push(6'o22); do_push(6'o33); do_push(6'o55);
    chk("t3_full_count", int'(count), 4);
    chk("t3_full_ready", int'(push_ready), 0);
    push_valid = 1'b1; push_addr = SELF;
    tick(); tick();
    chk("t3_full_self_refused", int'(self_valid), 0);
    chk("t3_full_count_hold", int'(count), 4);
    push_addr = 6'o01;
    tick();
    chk("t3_full_count_hold2", int'(count), 4);
    inj_ready = 1'b1;
    tick();
    inj_ready = 1'b0;
    chk("t3_pop_count", int'(count), 3);
    chk("t3_pop_ready", int'(push_ready), 1);
    @(negedge clk);
    if (push_ready) exp_head.push_back(6'o01);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    chk("t3_refill_count", int'(count), 4);
    drain();

    // 4: simultaneous push and pop at count=2 across pointer wrap
    do_push(6'o13); do_push(6'o14);
    chk("t4_count_start", int'(count), 2);
    for (int i = 0; i < 5; i++) begin
      push_valid = 1'b1; push_addr = tbl[i]; inj_ready = 1'b1;
      @(negedge clk);
      if (push_ready) exp_head.push_back(tbl[i]);
      else chk("t4_ready", 0, 1);
      @(posedge clk);
      #1;
      chk("t4_count_steady", int'(count), 2);
    end
    push_valid = 1'b0; inj_ready = 1'b0;
    drain();

    // 5: self-addressed push at count=1 loops back
    do_push(6'o07);
    do_push(SELF);
    chk("t5_self_valid", int'(self_valid), 1);
    chk("t5_self_addr", int'(self_addr), int'(SELF));
    chk("t5_count", int'(count), 1);
    tick();
    chk("t5_self_pulse_end", int'(self_valid), 0);
    drain();

    // rst overrides a same-cycle push and pop
    do_push(6'o17);
    exp_head.delete();
    rst = 1'b1; push_valid = 1'b1; push_addr = 6'o26; inj_ready = 1'b1;
    tick();
    rst = 1'b0; push_valid = 1'b0; inj_ready = 1'b0;
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_head", int'(head_valid), 0);

`ifdef INJ_STARVE_CNT_EN
    // 6: starvation flag
    do_push(6'o23);
    repeat (7) tick();
    chk("t6_starve_7", int'(starve), 0);
    tick();
    chk("t6_starve_8", int'(starve), 1);
    inj_ready = 1'b1;
    tick();
    inj_ready = 1'b0;
    chk("t6_starve_drop", int'(starve), 0);
    do_push(6'o24);
    repeat (5) tick();
    exp_head.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_push(6'o25);
    repeat (7) tick();
    chk("t6_rst_cleared", int'(starve), 0);
    drain();
`else
    chk("starve_tied", int'(starve), 0);
`endif

    chk("sb_head_empty", exp_head.size(), 0);
    chk("sb_self_empty", exp_self.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
